// File: rtl/stop_unit_pkg.sv
// Shared decode constants, timing type and classification helper for the stall unit.
// Latency: n/a (package only).
// Backpressure: n/a.
package stop_unit_pkg;

    // Pipeline-distance type used for Tuse / Tnew (values 0..2).
    typedef logic [1:0] tim_t;

    localparam tim_t TIM_0 = 2'd0;
    localparam tim_t TIM_1 = 2'd1;
    localparam tim_t TIM_2 = 2'd2;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Link register written by jal.
    localparam logic [4:0] REG_RA = 5'd31;

    // Instruction classes that matter for hazard detection.
    typedef enum logic [3:0] {
        K_NONE,
        K_ALU_R,
        K_JR,
        K_ORI,
        K_LUI,
        K_LW,
        K_SW,
        K_BEQ,
        K_JAL
    } instr_kind_e;

    // Map opcode/funct to a class; anything unrecognised (incl. nop) is K_NONE.
    function automatic instr_kind_e classify(input logic [5:0] op, input logic [5:0] funct);
        instr_kind_e k;
        k = K_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB: k = K_ALU_R;
                    FN_JR:          k = K_JR;
                    default:        k = K_NONE;
                endcase
            end
            OP_ORI:  k = K_ORI;
            OP_LUI:  k = K_LUI;
            OP_LW:   k = K_LW;
            OP_SW:   k = K_SW;
            OP_BEQ:  k = K_BEQ;
            OP_JAL:  k = K_JAL;
            default: k = K_NONE;
        endcase
        return k;
    endfunction

    // A read-after-write hazard that forwarding cannot cover in time.
    function automatic logic raw_hazard(
        input logic       src_use,
        input logic [4:0] src,
        input logic [4:0] dst,
        input tim_t       tuse,
        input tim_t       tnew
    );
        return src_use && (src == dst) && (dst != 5'd0) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/stop_unit_if.sv
// Bundle of the three stage instruction words and the stall outputs.
// Latency: n/a (wiring only).
// Backpressure: none; putoff itself is the pipeline's backpressure signal.
interface stop_unit_if;
    logic [31:0] D_instr;
    logic [31:0] E_instr;
    logic [31:0] M_instr;
    logic        putoff;
    logic [31:0] stall_cnt;

    // Pipeline side: supplies instruction words, consumes the stall request.
    modport master (
        output D_instr,
        output E_instr,
        output M_instr,
        input  putoff,
        input  stall_cnt
    );

    // Stall unit side.
    modport slave (
        input  D_instr,
        input  E_instr,
        input  M_instr,
        output putoff,
        output stall_cnt
    );
endinterface

// File: rtl/stop_unit_instr_decode.sv
// Per-stage decoder: source use flags, Tuse per source, destination and Tnew at E.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module instr_decode
    import stop_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic        rs_use,
    output logic        rt_use,
    output tim_t        tuse_rs,
    output tim_t        tuse_rt,
    output logic [4:0]  dst,
    output tim_t        tnew_e
);

    instr_kind_e kind;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [9:0]  unused_bits;

    assign kind = classify(instr[31:26], instr[5:0]);
    assign rt   = instr[20:16];
    assign rd   = instr[15:11];

    // rs is compared at the top level; shamt plays no part in hazards.
    assign unused_bits = {instr[25:21], instr[10:6]};

    // Derive per-class operand timing and write-back target.
    always_comb begin
        rs_use  = 1'b0;
        rt_use  = 1'b0;
        tuse_rs = TIM_0;
        tuse_rt = TIM_0;
        dst     = 5'd0;
        tnew_e  = TIM_0;
        case (kind)
            K_ALU_R: begin
                rs_use  = 1'b1;
                rt_use  = 1'b1;
                tuse_rs = TIM_1;
                tuse_rt = TIM_1;
                dst     = rd;
                tnew_e  = TIM_1;
            end
            K_JR: begin
                rs_use  = 1'b1;
                tuse_rs = TIM_0;
            end
            K_ORI: begin
                rs_use  = 1'b1;
                tuse_rs = TIM_1;
                dst     = rt;
                tnew_e  = TIM_1;
            end
            K_LUI: begin
                dst     = rt;
                tnew_e  = TIM_1;
            end
            K_LW: begin
                rs_use  = 1'b1;
                tuse_rs = TIM_1;
                dst     = rt;
                tnew_e  = TIM_2;
            end
            K_SW: begin
                // Store data is only needed at M, the base address at E.
                rs_use  = 1'b1;
                rt_use  = 1'b1;
                tuse_rs = TIM_1;
                tuse_rt = TIM_2;
            end
            K_BEQ: begin
                // Branch compares in D, so both operands are due now.
                rs_use  = 1'b1;
                rt_use  = 1'b1;
                tuse_rs = TIM_0;
                tuse_rt = TIM_0;
            end
            K_JAL: begin
                // Link address is available as soon as jal reaches E.
                dst     = REG_RA;
                tnew_e  = TIM_0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/stop_unit.sv
// Stall detector: raises putoff when D needs a register E/M cannot forward in time; counts stall cycles.
// Latency: putoff combinational (zero cycles); stall_cnt updates on the edge ending each stall cycle.
// Backpressure: putoff freezes PC/D and flushes E; the counter saturates at all-ones.
module stop_unit
    import stop_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    stop_unit_if.slave   bus
);

    // D stage needs
    logic        d_rs_use;
    logic        d_rt_use;
    tim_t        d_tuse_rs;
    tim_t        d_tuse_rt;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_unused_dst;
    tim_t        d_unused_tnew;

    // E stage production
    logic        e_unused_rs_use;
    logic        e_unused_rt_use;
    tim_t        e_unused_tuse_rs;
    tim_t        e_unused_tuse_rt;
    logic [4:0]  e_dst;
    tim_t        e_tnew;

    // M stage production
    logic        m_unused_rs_use;
    logic        m_unused_rt_use;
    tim_t        m_unused_tuse_rs;
    tim_t        m_unused_tuse_rt;
    logic [4:0]  m_dst;
    tim_t        m_tnew_e;
    tim_t        m_tnew;

    logic        stall_rs_e;
    logic        stall_rt_e;
    logic        stall_rs_m;
    logic        stall_rt_m;
    logic        putoff_w;
    logic [31:0] stall_cnt_q;

    instr_decode u_dec_d (
        .instr   (bus.D_instr),
        .rs_use  (d_rs_use),
        .rt_use  (d_rt_use),
        .tuse_rs (d_tuse_rs),
        .tuse_rt (d_tuse_rt),
        .dst     (d_unused_dst),
        .tnew_e  (d_unused_tnew)
    );

    instr_decode u_dec_e (
        .instr   (bus.E_instr),
        .rs_use  (e_unused_rs_use),
        .rt_use  (e_unused_rt_use),
        .tuse_rs (e_unused_tuse_rs),
        .tuse_rt (e_unused_tuse_rt),
        .dst     (e_dst),
        .tnew_e  (e_tnew)
    );

    instr_decode u_dec_m (
        .instr   (bus.M_instr),
        .rs_use  (m_unused_rs_use),
        .rt_use  (m_unused_rt_use),
        .tuse_rs (m_unused_tuse_rs),
        .tuse_rt (m_unused_tuse_rt),
        .dst     (m_dst),
        .tnew_e  (m_tnew_e)
    );

    assign d_rs = bus.D_instr[25:21];
    assign d_rt = bus.D_instr[20:16];

    // One stage further on, the result is one cycle closer (never below zero).
    assign m_tnew = (m_tnew_e == TIM_0) ? TIM_0 : tim_t'(m_tnew_e - 2'd1);

    assign stall_rs_e = raw_hazard(d_rs_use, d_rs, e_dst, d_tuse_rs, e_tnew);
    assign stall_rt_e = raw_hazard(d_rt_use, d_rt, e_dst, d_tuse_rt, e_tnew);
    assign stall_rs_m = raw_hazard(d_rs_use, d_rs, m_dst, d_tuse_rs, m_tnew);
    assign stall_rt_m = raw_hazard(d_rt_use, d_rt, m_dst, d_tuse_rt, m_tnew);

    assign putoff_w = stall_rs_e | stall_rt_e | stall_rs_m | stall_rt_m;

    // Count cycles that ended stalled; an unknown putoff is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if ((putoff_w === 1'b1) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.putoff    = putoff_w;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stop_unit.sv
module tb_stop_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    stop_unit_if bus();

    stop_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] w;
        w = {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] w;
        w = {op, 5'(rs), 5'(rt), imm};
        return w;
    endfunction

    // ---------------- reference model ----------------
    // Cycles until source 'which' (0 = rs, 1 = rt) is needed; -1 if not read.
    function automatic int src_tuse(input logic [31:0] ins, input int which);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 0 && (fn == 32 || fn == 34)) return 1;
        if (op == 0 && fn == 8)                return (which == 0) ? 0 : -1;
        if (op == 13 || op == 35)              return (which == 0) ? 1 : -1;
        if (op == 43)                          return (which == 0) ? 1 : 2;
        if (op == 4)                           return 0;
        return -1;
    endfunction

    // Register written, or -1.
    function automatic int dst_reg(input logic [31:0] ins);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 0 && (fn == 32 || fn == 34)) return int'(ins[15:11]);
        if (op == 13 || op == 15 || op == 35)  return int'(ins[20:16]);
        if (op == 3)                           return 31;
        return -1;
    endfunction

    // Cycles, counted from E, until the result can be forwarded.
    function automatic int result_delay(input logic [31:0] ins);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 35)                                   return 2;
        if (op == 0 && (fn == 32 || fn == 34))          return 1;
        if (op == 13 || op == 15)                       return 1;
        return 0;
    endfunction

    function automatic logic model_putoff(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        logic [31:0] prod [2];
        logic        stall;
        prod[0] = e;
        prod[1] = m;
        stall   = 1'b0;
        for (int which = 0; which < 2; which++) begin
            int need;
            int r;
            need = src_tuse(d, which);
            r    = (which == 0) ? int'(d[25:21]) : int'(d[20:16]);
            if (need >= 0) begin
                for (int age = 0; age < 2; age++) begin
                    int w;
                    int remain;
                    w      = dst_reg(prod[age]);
                    remain = result_delay(prod[age]) - age;
                    if (remain < 0) remain = 0;
                    if (w > 0 && w == r && need < remain) stall = 1'b1;
                end
            end
        end
        return stall;
    endfunction

    // Random instruction biased toward a small register pool so hazards occur often.
    function automatic int rreg();
        int pool [4];
        pool = '{0, 1, 2, 31};
        return pool[$urandom_range(0, 3)];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [15:0] imm;
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0: w = enc_r(rreg(), rreg(), rreg(), 6'b100000);
            1: w = enc_r(rreg(), rreg(), rreg(), 6'b100010) | {21'd0, 5'($urandom), 6'd0};
            2: w = enc_r(rreg(), rreg(), rreg(), 6'b001000);
            3: w = enc_i(6'b001101, rreg(), rreg(), imm);
            4: w = enc_i(6'b001111, rreg(), rreg(), imm);
            5: w = enc_i(6'b100011, rreg(), rreg(), imm);
            6: w = enc_i(6'b101011, rreg(), rreg(), imm);
            7: w = enc_i(6'b000100, rreg(), rreg(), imm);
            8: w = {6'b000011, 26'($urandom)};
            default: w = enc_r(rreg(), rreg(), rreg(), 6'b100101);
        endcase
        return w;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        bus.D_instr = d;
        bus.E_instr = e;
        bus.M_instr = m;
    endtask

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] m;
        logic        exp;
    } vec_t;

    localparam logic [31:0] JR31     = 32'h03FF_FFC8;
    localparam logic [31:0] ADD_R0   = 32'h0000_0020;
    localparam logic [31:0] BEQ89    = 32'h1109_0000;
    localparam logic [31:0] ADD8     = 32'h0022_4020;
    localparam logic [31:0] LW4      = 32'h8C04_0000;
    localparam logic [31:0] LW6      = 32'h8C06_0000;
    localparam logic [31:0] LW31     = 32'h8C1F_0000;
    localparam logic [31:0] JAL      = 32'h0C00_0000;

    vec_t        vecs [$];
    logic [31:0] exp_cnt;
    logic        exp_p;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(32'd0, 32'd0, 32'd0);

        vecs.push_back('{"jr31_vs_add_r0",    JR31, ADD_R0, 32'd0, 1'b0});
        vecs.push_back('{"beq_vs_E_add",      BEQ89, ADD8, 32'd0, 1'b1});
        vecs.push_back('{"beq_vs_M_add",      BEQ89, 32'd0, ADD8, 1'b0});
        vecs.push_back('{"add_vs_E_lw",       enc_r(4, 5, 3, 6'b100000), LW4, 32'd0, 1'b1});
        vecs.push_back('{"add_vs_M_lw",       enc_r(4, 5, 3, 6'b100000), 32'd0, LW4, 1'b0});
        // Store data is consumed at M; lw's value is forwardable by then.
        vecs.push_back('{"sw_data_vs_E_lw",   enc_i(6'b101011, 7, 6, 16'd0), LW6, 32'd0, 1'b0});
        vecs.push_back('{"sw_base_vs_E_lw",   enc_i(6'b101011, 6, 7, 16'd0), LW6, 32'd0, 1'b1});
        vecs.push_back('{"sw_base_vs_M_lw",   enc_i(6'b101011, 6, 7, 16'd0), 32'd0, LW6, 1'b0});
        vecs.push_back('{"jr_vs_E_jal",       JR31, JAL, 32'd0, 1'b0});
        vecs.push_back('{"jr_vs_M_lw31",      JR31, 32'd0, LW31, 1'b1});
        vecs.push_back('{"jr_E_jal_M_lw31",   JR31, JAL, LW31, 1'b1});
        vecs.push_back('{"beq_r0_all_r0",     32'h1000_0000, ADD_R0, 32'h8C00_0000, 1'b0});
        vecs.push_back('{"ori_vs_E_add",      enc_i(6'b001101, 8, 9, 16'h1), ADD8, 32'd0, 1'b0});
        vecs.push_back('{"ori_vs_E_lw",       enc_i(6'b001101, 8, 9, 16'h1), enc_i(6'b100011, 0, 8, 16'd4), 32'd0, 1'b1});
        vecs.push_back('{"lui_vs_E_lw",       enc_i(6'b001111, 0, 4, 16'h1), LW4, 32'd0, 1'b0});
        vecs.push_back('{"nop_vs_E_lw",       32'd0, LW4, LW4, 1'b0});
        vecs.push_back('{"beq_rt_vs_E_ori",   BEQ89, enc_i(6'b001101, 0, 9, 16'h5), 32'd0, 1'b1});
        vecs.push_back('{"beq_rs_vs_M_lw",    BEQ89, 32'd0, enc_i(6'b100011, 0, 8, 16'd0), 1'b1});
        vecs.push_back('{"add_rt_vs_E_lui",   enc_r(4, 5, 3, 6'b100000), enc_i(6'b001111, 0, 5, 16'h1), 32'd0, 1'b0});

        // Table held under reset: putoff must still track, counter must stay 0.
        #3;
        check("reset_cnt", bus.stall_cnt, 32'd0);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].d, vecs[i].e, vecs[i].m);
            #1;
            check(vecs[i].name, {31'd0, bus.putoff}, {31'd0, vecs[i].exp});
        end
        @(posedge clk);
        #1;
        check("cnt_held_in_reset", bus.stall_cnt, 32'd0);

        // Random traffic against the model, with running stall count.
        @(negedge clk);
        drive(32'd0, 32'd0, 32'd0);
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k % 50 == 0) check("rand_cnt", bus.stall_cnt, exp_cnt);
            else if (bus.stall_cnt !== exp_cnt) check("rand_cnt", bus.stall_cnt, exp_cnt);
            drive(rand_instr(), rand_instr(), rand_instr());
            #1;
            exp_p = model_putoff(bus.D_instr, bus.E_instr, bus.M_instr);
            check("rand_putoff", {31'd0, bus.putoff}, {31'd0, exp_p});
            if (exp_p) exp_cnt = exp_cnt + 32'd1;
        end
        @(negedge clk);
        check("rand_cnt_final", bus.stall_cnt, exp_cnt);

        // Asynchronous clear, mid-cycle.
        rst_n = 1'b0;
        #1;
        check("async_clear_after_rand", bus.stall_cnt, 32'd0);
        @(negedge clk);
        drive(BEQ89, ADD8, 32'd0);
        rst_n = 1'b1;

        // Hold a stall for five edges.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("five_stalls", bus.stall_cnt, 32'd5);

        // Non-stalling instructions leave the count alone.
        drive(JR31, JAL, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("no_count_without_stall", bus.stall_cnt, 32'd5);

        // Reset pulse between edges clears at once.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_midcycle", bus.stall_cnt, 32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("cnt_after_release", bus.stall_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
